key_event_gen: RTL

//  Consumes a debounced, synchronised button level and turns it into one-cycle events:

---
 rtl/key_event_pkg.sv | 22 ++
 rtl/key_event_if.sv | 33 +++
 rtl/key_edge_det.sv | 22 ++
 rtl/key_event_gen.sv | 113 +++++++++++
 4 files changed

// File: rtl/key_event_pkg.sv
// Shared types and constants for the button event generator.
// Holds the FSM state encoding, the default timing values and the counter width helper.
package key_event_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } key_state_t;

  localparam int unsigned DEF_LONG_CYCLES   = 100_000_000;
  localparam int unsigned DEF_REPEAT_CYCLES = 20_000_000;

  // Width needed to hold the larger of the two terminal counts.
  function automatic int cnt_width(input int unsigned long_cycles,
                                   input int unsigned repeat_cycles);
    int unsigned larger;
    larger = (long_cycles > repeat_cycles) ? long_cycles : repeat_cycles;
    return $clog2(larger);
  endfunction

endpackage

// File: rtl/key_event_if.sv
// Button level in, one-cycle key events out.
// The generator takes the master side; the consumer takes the slave side.
interface key_event_if;

  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic click_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic held;

  modport master (
    input  btn_level,
    output press_pulse,
    output release_pulse,
    output click_pulse,
    output long_pulse,
    output repeat_pulse,
    output held
  );

  modport slave (
    output btn_level,
    input  press_pulse,
    input  release_pulse,
    input  click_pulse,
    input  long_pulse,
    input  repeat_pulse,
    input  held
  );

endinterface

// File: rtl/key_edge_det.sv
// Rise/fall detector for an already-clean level.
// The history flop clears to 0, so a level high at reset release reads as a rise.
module key_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise,
  output logic fall
);

  logic level_q;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_q <= 1'b0;
    else     level_q <= level;
  end

  assign rise = level & ~level_q;
  assign fall = ~level & level_q;

endmodule

// File: rtl/key_event_gen.sv
// Turns a debounced button level into registered one-cycle press, release,
// click, long-press and auto-repeat events, plus a registered held level.
module key_event_gen
  import key_event_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter bit          REPEAT_EN     = 1'b1
) (
  input logic       clk,
  input logic       rst,
  key_event_if.master ev
);

  localparam int CNT_W = cnt_width(LONG_CYCLES, REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  logic rise;
  logic fall;

  key_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic press_next, release_next, click_next, long_next, repeat_next;

  key_edge_det u_edge (
    .clk   (clk),
    .rst   (rst),
    .level (ev.btn_level),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      ev.press_pulse   <= 1'b0;
      ev.release_pulse <= 1'b0;
      ev.click_pulse   <= 1'b0;
      ev.long_pulse    <= 1'b0;
      ev.repeat_pulse  <= 1'b0;
      ev.held          <= 1'b0;
    end else begin
      state            <= state_next;
      cnt              <= cnt_next;
      ev.press_pulse   <= press_next;
      ev.release_pulse <= release_next;
      ev.click_pulse   <= click_next;
      ev.long_pulse    <= long_next;
      ev.repeat_pulse  <= repeat_next;
      // Registered from next state so held cannot glitch on a two-bit state change.
      ev.held          <= (state_next != IDLE);
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    press_next   = 1'b0;
    release_next = 1'b0;
    click_next   = 1'b0;
    long_next    = 1'b0;
    repeat_next  = 1'b0;

    unique case (state)
      IDLE: begin
        if (rise) begin
          state_next = PRESSED;
          cnt_next   = '0;
          press_next = 1'b1;
        end
      end

      // A fall is checked first so it beats a threshold hit in the same cycle.
      PRESSED: begin
        if (fall) begin
          state_next   = IDLE;
          cnt_next     = '0;
          release_next = 1'b1;
          click_next   = 1'b1;
        end else if (cnt == LONG_LAST) begin
          state_next = LONG_HELD;
          cnt_next   = '0;
          long_next  = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      LONG_HELD: begin
        if (fall) begin
          state_next   = IDLE;
          cnt_next     = '0;
          release_next = 1'b1;
        end else if (REPEAT_EN && (cnt == REPEAT_LAST)) begin
          cnt_next    = '0;
          repeat_next = 1'b1;
        end else if (cnt != CNT_MAX) begin
          cnt_next = cnt + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule
